// File: rtl/squash_game_ctrl.sv
// Squash game-sequencing controller: attract/serve/play/over flow, lives, score, core control.
// Optional build macro SCORE_BCD_EN selects a two-digit packed-BCD score instead of binary.
module squash_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_n,
  input  logic       pause_btn_n,
  input  logic       hit,
  input  logic       ball_miss,
  output logic       core_new_game_n,
  output logic       core_pause_n,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [1:0] state,
  output logic       game_over
);

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_SERVE   = 2'd1,
    ST_PLAY    = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  localparam int TMAX = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] SERVE_LOAD = TW'(SERVE_FRAMES - 1);
  localparam logic [TW-1:0] OVER_LOAD  = TW'(OVER_FRAMES - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_paused;
  logic [7:0]    r_score;
  logic [1:0]    r_lives;
  logic          r_new_game_n;
  logic          r_pause_n;
  logic          r_game_over;
  logic [1:0]    r_start_s;
  logic [1:0]    r_pause_s;
  logic          r_hit_q;

  logic          w_start_press;
  logic          w_pause_press;
  logic          w_hit_edge;
  logic [7:0]    w_score_inc;

  function automatic logic [7:0] f_score_inc(input logic [7:0] s);
`ifdef SCORE_BCD_EN
    if (s == 8'h99)
      return s;
    else if (s[3:0] == 4'd9)
      return {s[7:4] + 4'd1, 4'd0};
    else
      return {s[7:4], s[3:0] + 4'd1};
`else
    if (s == 8'hFF)
      return s;
    else
      return s + 8'd1;
`endif
  endfunction

  // [0] holds the newest frame sample, [1] the one before it.
  assign w_start_press = frame_tick & r_start_s[1] & ~r_start_s[0];
  assign w_pause_press = frame_tick & r_pause_s[1] & ~r_pause_s[0];
  assign w_hit_edge    = hit & ~r_hit_q;
  assign w_score_inc   = f_score_inc(r_score);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_ATTRACT;
      r_timer      <= '0;
      r_paused     <= 1'b0;
      r_score      <= '0;
      r_lives      <= LIVES_INIT;
      r_new_game_n <= 1'b0;
      r_pause_n    <= 1'b0;
      r_game_over  <= 1'b0;
      r_start_s    <= '1;
      r_pause_s    <= '1;
      r_hit_q      <= 1'b0;
    end else begin
      r_hit_q <= hit;
      if (frame_tick) begin
        r_start_s <= {r_start_s[0], start_n};
        r_pause_s <= {r_pause_s[0], pause_btn_n};
      end

      case (r_state)
        ST_ATTRACT: begin
          if (w_start_press) begin
            r_state <= ST_SERVE;
            r_score <= '0;
            r_lives <= LIVES_INIT;
            r_timer <= SERVE_LOAD;
          end
        end

        ST_SERVE: begin
          r_paused <= 1'b0;
          if (frame_tick) begin
            if (r_timer == '0) begin
              r_state      <= ST_PLAY;
              r_new_game_n <= 1'b1;
              r_pause_n    <= 1'b1;
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
        end

        ST_PLAY: begin
          if (w_hit_edge && !r_paused)
            r_score <= w_score_inc;
          // Miss uses the pre-toggle pause flag, so it takes priority over a same-tick pause press.
          if (frame_tick && ball_miss && !r_paused) begin
            r_paused  <= 1'b0;
            r_pause_n <= 1'b0;
            if (r_lives == 2'd1) begin
              r_state     <= ST_OVER;
              r_lives     <= '0;
              r_timer     <= OVER_LOAD;
              r_game_over <= 1'b1;
            end else begin
              r_state      <= ST_SERVE;
              r_lives      <= r_lives - 2'd1;
              r_timer      <= SERVE_LOAD;
              r_new_game_n <= 1'b0;
            end
          end else if (w_pause_press) begin
            r_paused  <= ~r_paused;
            r_pause_n <= r_paused;
          end
        end

        ST_OVER: begin
          if (frame_tick) begin
            if (r_timer == '0) begin
              r_state      <= ST_ATTRACT;
              r_lives      <= LIVES_INIT;
              r_new_game_n <= 1'b0;
              r_game_over  <= 1'b0;
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
        end

        default: r_state <= ST_ATTRACT;
      endcase
    end
  end

  assign core_new_game_n = r_new_game_n;
  assign core_pause_n    = r_pause_n;
  assign score           = r_score;
  assign lives           = r_lives;
  assign state           = r_state;
  assign game_over       = r_game_over;

endmodule

// File: tb/tb_squash_game_ctrl.sv
// Scoreboard bench for squash_game_ctrl: stimulus queues expected snapshots, a monitor compares them.
module tb_squash_game_ctrl;

`ifdef SCORE_BCD_EN
  localparam logic [7:0] SC10  = 8'h10;
  localparam logic [7:0] SC11  = 8'h11;
  localparam logic [7:0] SC12  = 8'h12;
  localparam logic [7:0] SCMAX = 8'h99;
`else
  localparam logic [7:0] SC10  = 8'h0A;
  localparam logic [7:0] SC11  = 8'h0B;
  localparam logic [7:0] SC12  = 8'h0C;
  localparam logic [7:0] SCMAX = 8'hFF;
`endif

  logic       clk = 1'b0;
  logic       reset, frame_tick, start_n, pause_btn_n, hit, ball_miss;
  logic       core_new_game_n, core_pause_n, game_over;
  logic [7:0] score;
  logic [1:0] lives, state;

  squash_game_ctrl #(.LIVES(3), .SERVE_FRAMES(60), .OVER_FRAMES(180)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_n(start_n),
    .pause_btn_n(pause_btn_n), .hit(hit), .ball_miss(ball_miss),
    .core_new_game_n(core_new_game_n), .core_pause_n(core_pause_n),
    .score(score), .lives(lives), .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic [1:0] lv;
    logic [7:0] sc;
    logic       ngn;
    logic       pn;
    logic       go;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_total = 0;
  int   n_pass  = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      m_e = q.pop_front();
      n_total++;
      if (state === m_e.st && lives === m_e.lv && score === m_e.sc &&
          core_new_game_n === m_e.ngn && core_pause_n === m_e.pn && game_over === m_e.go)
        n_pass++;
      else
        $display("FAIL %s: got st=%0d lv=%0d sc=%h ngn=%b pn=%b go=%b, want st=%0d lv=%0d sc=%h ngn=%b pn=%b go=%b",
                 m_e.name, state, lives, score, core_new_game_n, core_pause_n, game_over,
                 m_e.st, m_e.lv, m_e.sc, m_e.ngn, m_e.pn, m_e.go);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hitp();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    cyc();
  endtask

  task automatic chk(input string nm, input logic [1:0] st, input logic [1:0] lv,
                     input logic [7:0] sc, input logic ngn, input logic pn);
    exp_t e;
    e.name = nm; e.st = st; e.lv = lv; e.sc = sc; e.ngn = ngn; e.pn = pn;
    e.go   = (st == 2'd3);
    q.push_back(e);
  endtask

  task automatic start_game();
    start_n = 1'b0;
    tick();
    tick();
    start_n = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; start_n = 1'b1; pause_btn_n = 1'b1;
    hit = 1'b0; ball_miss = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    chk("reset", 2'd0, 2'd3, 8'h00, 1'b0, 1'b0);

    // Start needs two frame samples.
    start_n = 1'b0;
    tick();
    chk("start_one_tick", 2'd0, 2'd3, 8'h00, 1'b0, 1'b0);
    tick();
    chk("start_serve", 2'd1, 2'd3, 8'h00, 1'b0, 1'b0);
    start_n = 1'b1;
    ticks(59);
    chk("serve_59", 2'd1, 2'd3, 8'h00, 1'b0, 1'b0);
    tick();
    chk("serve_to_play", 2'd2, 2'd3, 8'h00, 1'b1, 1'b1);

    for (int i = 0; i < 10; i++) hitp();
    chk("ten_hits", 2'd2, 2'd3, SC10, 1'b1, 1'b1);
    hit = 1'b1;
    tick();
    tick();
    hit = 1'b0;
    cyc();
    chk("long_hit_once", 2'd2, 2'd3, SC11, 1'b1, 1'b1);

    ball_miss = 1'b1; tick(); ball_miss = 1'b0;
    chk("miss1", 2'd1, 2'd2, SC11, 1'b0, 1'b0);
    ticks(60);
    chk("replay1", 2'd2, 2'd2, SC11, 1'b1, 1'b1);
    ball_miss = 1'b1; tick(); ball_miss = 1'b0;
    chk("miss2", 2'd1, 2'd1, SC11, 1'b0, 1'b0);
    ticks(60);
    chk("replay2", 2'd2, 2'd1, SC11, 1'b1, 1'b1);

    hit = 1'b1; ball_miss = 1'b1; frame_tick = 1'b1;
    cyc();
    hit = 1'b0; ball_miss = 1'b0; frame_tick = 1'b0;
    cyc();
    chk("hit_and_last_miss", 2'd3, 2'd0, SC12, 1'b1, 1'b0);

    start_n = 1'b0;
    tick(); tick();
    start_n = 1'b1;
    ticks(177);
    chk("over_179", 2'd3, 2'd0, SC12, 1'b1, 1'b0);
    tick();
    chk("over_to_attract", 2'd0, 2'd3, SC12, 1'b0, 1'b0);

    start_game();
    chk("game2_serve", 2'd1, 2'd3, 8'h00, 1'b0, 1'b0);
    pause_btn_n = 1'b0;
    tick(); tick();
    pause_btn_n = 1'b1;
    ticks(58);
    chk("serve_pause_ignored", 2'd2, 2'd3, 8'h00, 1'b1, 1'b1);

    pause_btn_n = 1'b0;
    tick(); tick();
    chk("paused", 2'd2, 2'd3, 8'h00, 1'b1, 1'b0);
    pause_btn_n = 1'b1;
    tick();
    hitp();
    ball_miss = 1'b1; tick(); ball_miss = 1'b0;
    chk("paused_ignores", 2'd2, 2'd3, 8'h00, 1'b1, 1'b0);
    pause_btn_n = 1'b0;
    tick(); tick();
    chk("unpaused", 2'd2, 2'd3, 8'h00, 1'b1, 1'b1);

    pause_btn_n = 1'b1; tick();
    pause_btn_n = 1'b0; tick();
    ball_miss = 1'b1; tick(); ball_miss = 1'b0;
    pause_btn_n = 1'b1;
    chk("pause_and_miss", 2'd1, 2'd2, 8'h00, 1'b0, 1'b0);
    ticks(60);
    chk("paused_cleared", 2'd2, 2'd2, 8'h00, 1'b1, 1'b1);

    for (int i = 0; i < 300; i++) hitp();
    chk("score_saturate", 2'd2, 2'd2, SCMAX, 1'b1, 1'b1);

    reset = 1'b1; cyc(); reset = 1'b0;
    chk("reset_after_sat", 2'd0, 2'd3, 8'h00, 1'b0, 1'b0);
    start_game();
    ticks(60);
    for (int i = 0; i < 5; i++) hitp();
    pause_btn_n = 1'b0;
    tick(); tick();
    pause_btn_n = 1'b1;
    chk("score5_paused", 2'd2, 2'd3, 8'h05, 1'b1, 1'b0);
    reset = 1'b1;
    cyc();
    chk("reset_mid_play", 2'd0, 2'd3, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;

    cyc(); cyc(); cyc();
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
